// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and load/store traffic.
// Load/store wins contests, except that a streak counter periodically forces fetch through.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_done_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wr_en_o,
  output logic              mem_out_en_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_ls_q, owner_ls_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LW-1:0]       lat_cnt_q, lat_cnt_d;
  logic [SW-1:0]       streak_q, streak_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                if_gnt_q, if_gnt_d;
  logic                ls_gnt_q, ls_gnt_d;
  logic                grant_ls;

  // Load/store wins unless fetch is also waiting and has been passed over STARVE_MAX times.
  assign grant_ls = ls_req_i && !(if_req_i && (streak_q == SW'(STARVE_MAX)));

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_cnt_d  = lat_cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i || ls_req_i) begin
          state_d    = ACCESS;
          owner_ls_d = grant_ls;
          we_d       = grant_ls && ls_we_i;
          addr_d     = grant_ls ? ls_addr_i : if_addr_i;
          wdata_d    = grant_ls ? ls_wdata_i : '0;
          lat_cnt_d  = LW'(MEM_LAT - 1);
          if_gnt_d   = !grant_ls;
          ls_gnt_d   = grant_ls;
          // A contested load/store win can only happen below STARVE_MAX, so the increment saturates.
          if (if_req_i && ls_req_i) begin
            streak_d = grant_ls ? streak_q + 1'b1 : '0;
          end else if (!grant_ls) begin
            streak_d = '0;
          end
        end
      end
      ACCESS: begin
        if (lat_cnt_q == '0) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_ls_q) ls_rdata_d = mem_rdata_i;
            else            if_rdata_d = mem_rdata_i;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt_q  <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_cnt_q  <= lat_cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_gnt_q   <= if_gnt_d;
      ls_gnt_q   <= ls_gnt_d;
    end
  end

  // Enables decode straight from state so an asynchronous reset drops them without a clock.
  assign mem_wr_en_o  = (state_q == ACCESS) && we_q;
  assign mem_out_en_o = (state_q == ACCESS) && !we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = (state_q != IDLE);
  assign if_gnt_o     = if_gnt_q;
  assign ls_gnt_o     = ls_gnt_q;
  assign if_done_o    = (state_q == RESP) && !owner_ls_q;
  assign ls_done_o    = (state_q == RESP) && owner_ls_q;
  assign if_rdata_o   = if_rdata_q;
  assign ls_rdata_o   = ls_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared RAM port between the instruction-fetch path (PC-addressed reads) and the load/store path (LDUR/STUR/LDURB/STURB traffic), so the control unit no longer multiplexes both through one control word. It latches the winning request, holds the RAM address and enables stable for a fixed access latency, captures read data, and returns a one-cycle completion pulse. Load/store normally wins conflicts; a streak counter guarantees fetch forward progress.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MEM_LAT, 2, cycles the RAM needs address/enable held per access (>=1)
- STARVE_MAX, 4, consecutive contested load/store wins before fetch is forced to win (>=1)

- clock  in  1  rising-edge clock; the block's one clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level; held until if_done
- if_addr  in  ADDR_W  fetch address (PC)
- if_gnt  out  1  one-cycle pulse: fetch request accepted and latched
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched word, registered
- ls_req  in  1  load/store request, level; held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  one-cycle pulse: load/store accepted and latched
- ls_done  out  1  one-cycle pulse: access complete, ls_rdata valid for loads
- ls_rdata  out  DATA_W  load data, registered
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wr_en  out  1  RAM write enable (WR_EN)
- mem_out_en  out  1  RAM output enable (OUT_EN)
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  1 whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: requests sampled only here. Neither asserted: stay. Exactly one: that requester wins. Both: ls wins unless streak == STARVE_MAX, then if wins.
- On the winning edge: latch owner, address, we (0 for fetch), wdata; load lat_cnt = MEM_LAT-1; go ACCESS.
- Streak: at a both-asserted arbitration, ls win -> streak+1; if win -> 0. Single-requester arbitration: unchanged if ls alone, 0 if if alone. Saturates at STARVE_MAX.
- ACCESS: mem_addr/mem_wdata driven from latches; mem_out_en = !we, mem_wr_en = we, constant for all MEM_LAT cycles. lat_cnt decrements; at lat_cnt == 0 go RESP; for reads, mem_rdata captured into the owner's rdata register on that edge.
- RESP: owner's done = 1, mem enables 0; go IDLE unconditionally.
- Stores leave ls_rdata unchanged. The non-owner's rdata never changes.
- Inputs other than req are ignored outside the grant edge; changing them mid-access has no effect.
- Requester clears req on the edge ending its done cycle if it has no further access; req still high in the next IDLE cycle is a new request.

## Timing
- Reset (asynchronous, reset = 0): state IDLE, lat_cnt 0, streak 0, all outputs 0 including if_rdata/ls_rdata, mem_addr, mem_wdata. Reset mid-access aborts it immediately: enables drop without waiting for clock, no done is issued, latched request is discarded.
- gnt is registered: high during the first ACCESS cycle only.
- Request raised in IDLE cycle 0 -> gnt cycle 1 -> enables cycles 1..MEM_LAT -> done cycle MEM_LAT+1 -> IDLE cycle MEM_LAT+2. Back-to-back accesses repeat every MEM_LAT+2 cycles.
- Exactly one of mem_wr_en/mem_out_en high per ACCESS cycle; both low in IDLE and RESP.
- gnt and done never asserted for both requesters in the same cycle.

## Test plan
- Fetch alone, MEM_LAT=2: if_req=1, if_addr=0x40, RAM[0x40]=0x8B020020 -> if_gnt cycle 1, mem_out_en cycles 1-2 with mem_addr=0x40, if_done cycle 3 with if_rdata=0x8B020020, busy low cycle 4.
- Store: ls_we=1, ls_addr=0x100, ls_wdata=0xDEADBEEF -> mem_wr_en cycles 1-2, mem_out_en 0 throughout, ls_done cycle 3, RAM[0x100]=0xDEADBEEF, ls_rdata unchanged.
- Simultaneous first contest: both req in same IDLE cycle -> ls_gnt cycle 1, if_gnt not before cycle 5 (next IDLE after ls_done), fetch completes cycle 7.
- Starvation, STARVE_MAX=4: if_req held high, ls_req re-asserted after every ls_done -> four ls grants, fifth arbitration grants fetch, streak returns 0, sixth grants ls.
- Reset mid-read: assert reset low in ACCESS cycle 1 -> mem_out_en, busy, if_rdata 0 immediately; no if_done; after release with if_req=1 a fresh grant follows normal timing.
- MEM_LAT=1 corner: single read -> gnt/enable cycle 1, done cycle 2, data captured correctly; idle inputs toggling during ACCESS do not alter mem_addr.
